// File: rtl/sm_clk_ctrl_pkg.sv
// sm_clk_ctrl_pkg: shared types and defaults for the clock divider controller
package sm_clk_ctrl_pkg;
  localparam int CODE_W = 4;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  typedef enum logic [2:0] {IDLE, WAIT_LOW, PAUSE, APPLY, SETTLE, ACK} state_e;
endpackage

// File: rtl/sm_rr_arbiter.sv
// sm_rr_arbiter: combinational round-robin pick of the first request at or after ptr
module sm_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);
  localparam int IW = $clog2(N);
  int j;
  always_comb begin
    idx = '0;
    valid = 1'b0;
    j = 0;
    // Scan downwards so the closest request to ptr is the last one assigned
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        idx = IW'(j);
        valid = 1'b1;
      end
    end
    gnt = valid ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/sm_clk_div_ctrl.sv
// sm_clk_div_ctrl: arbitrates divide-code changes and sequences them glitch-free into the divider
module sm_clk_div_ctrl import sm_clk_ctrl_pkg::*; #(
  parameter int                N_REQ          = 4,
  parameter logic [CODE_W-1:0] RESET_CODE     = '0,
  parameter int                SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int                TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [CODE_W*N_REQ-1:0]   req_code,
  output logic [N_REQ-1:0]          ack,
  input  logic                      div_clk,
  input  logic                      halt,
  input  logic                      clr_err,
  output logic [CODE_W-1:0]         clkDevide,
  output logic                      clkEnable,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  owner,
  output logic                      timeout_err
);
  localparam int IW = $clog2(N_REQ);
  localparam int CMAX = TIMEOUT_CYCLES > SETTLE_CYCLES ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CODE_W-1:0] code_q, code_d, dev_q, dev_d;
  logic [IW-1:0] owner_q, owner_d, ptr_q, ptr_d, arb_idx;
  logic [N_REQ-1:0] sel_q, sel_d, ack_q, arb_gnt;
  logic err_q, err_d, div_q, en_q, busy_q, arb_valid;
  sm_rr_arbiter #(.N(N_REQ)) u_arb (
    .req(req),
    .ptr(ptr_q),
    .gnt(arb_gnt),
    .idx(arb_idx),
    .valid(arb_valid)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    code_d = code_q;
    owner_d = owner_q;
    sel_d = sel_q;
    ptr_d = ptr_q;
    dev_d = dev_q;
    err_d = err_q & ~clr_err;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (arb_valid) begin
          state_d = WAIT_LOW;
          code_d = req_code[arb_idx*CODE_W +: CODE_W];
          owner_d = arb_idx;
          sel_d = arb_gnt;
        end
      end
      // No-op codes are detected against the latched code and skip the freeze entirely
      WAIT_LOW: begin
        if (code_q == dev_q) state_d = ACK;
        else if (!div_q || cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = PAUSE;
          err_d = err_d | div_q;
        end
      end
      PAUSE: state_d = APPLY;
      APPLY: begin
        state_d = SETTLE;
        dev_d = code_q;
        cnt_d = '0;
      end
      SETTLE: state_d = cnt_q == CW'(SETTLE_CYCLES - 1) ? ACK : SETTLE;
      ACK: begin
        state_d = IDLE;
        ptr_d = owner_q == IW'(N_REQ - 1) ? '0 : owner_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      code_q <= '0;
      owner_q <= '0;
      sel_q <= '0;
      ptr_q <= '0;
      dev_q <= RESET_CODE;
      err_q <= 1'b0;
      div_q <= 1'b0;
      en_q <= 1'b1;
      ack_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      code_q <= code_d;
      owner_q <= owner_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
      dev_q <= dev_d;
      err_q <= err_d;
      div_q <= div_clk;
      en_q <= !halt && !(state_d inside {PAUSE, APPLY, SETTLE});
      ack_q <= state_d == ACK ? sel_d : '0;
      busy_q <= state_d != IDLE;
    end
  end
  assign ack = ack_q;
  assign clkDevide = dev_q;
  assign clkEnable = en_q;
  assign busy = busy_q;
  assign owner = owner_q;
  assign timeout_err = err_q;
endmodule

// File: tb/tb_sm_clk_div_ctrl.sv
// tb_sm_clk_div_ctrl: scoreboard bench for the clock divider controller
module tb_sm_clk_div_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [15:0] req_code = '0;
  logic [3:0] ack;
  logic div_clk = 1'b0;
  logic halt = 1'b0;
  logic clr_err = 1'b0;
  logic [3:0] clkDevide;
  logic clkEnable, busy, timeout_err;
  logic [1:0] owner;
  typedef struct {
    int idx;
    logic [3:0] code;
  } exp_t;
  exp_t sb[$];
  exp_t e_mon;
  logic [3:0] prev_ack = '0;
  int n_chk = 0;
  int n_pass = 0;
  sm_clk_div_ctrl #(
    .N_REQ(4),
    .RESET_CODE(4'd0),
    .SETTLE_CYCLES(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .req_code(req_code),
    .ack(ack),
    .div_clk(div_clk),
    .halt(halt),
    .clr_err(clr_err),
    .clkDevide(clkDevide),
    .clkEnable(clkEnable),
    .busy(busy),
    .owner(owner),
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
  endtask
  always @(negedge clk) begin
    if (rst_n && ack != 0) begin
      chk("ack_onehot", $countones(ack), 1);
      chk("ack_pulse", prev_ack, 0);
      if (sb.size() == 0) chk("ack_unexpected", ack, 0);
      else begin
        e_mon = sb.pop_front();
        chk("ack_idx", ack, 32'd1 << e_mon.idx);
        chk("ack_owner", owner, e_mon.idx);
        chk("ack_code", clkDevide, e_mon.code);
      end
    end
    prev_ack = rst_n ? ack : '0;
  end
  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    halt = 1'b0;
    clr_err = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("t1_dev", clkDevide, 0);
      chk("t1_en", clkEnable, 1);
      chk("t1_busy", busy, 0);
      chk("t1_ack", ack, 0);
      chk("t1_err", timeout_err, 0);
    end
    chk("t1_owner", owner, 0);
    @(negedge clk);
    req_code = 16'h0050;
    req = 4'b0010;
    sb.push_back('{1, 4'd5});
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      chk("t2_en", clkEnable, (c >= 2 && c <= 7) ? 0 : 1);
      chk("t2_dev", clkDevide, c >= 4 ? 5 : 0);
      chk("t2_ack", ack, c == 8 ? 4'b0010 : 4'b0000);
      chk("t2_busy", busy, c <= 8 ? 1 : 0);
      if (c == 8) begin
        chk("t2_owner", owner, 1);
        req = '0;
      end
    end
    do_reset();
    req_code = 16'h9063;
    req = 4'b1011;
    sb.push_back('{0, 4'd3});
    sb.push_back('{1, 4'd6});
    sb.push_back('{3, 4'd9});
    for (int c = 0; c < 100 && req != 0; c++) begin
      @(posedge clk); #1;
      if (ack != 0) req = req & ~ack;
    end
    chk("t3_all_served", req, 0);
    repeat (2) @(posedge clk);
    chk("t3_sb_empty", sb.size(), 0);
    chk("t3_final_dev", clkDevide, 9);
    do_reset();
    div_clk = 1'b1;
    repeat (2) @(negedge clk);
    req_code = 16'h0700;
    req = 4'b0100;
    sb.push_back('{2, 4'd7});
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      chk("t4_en", clkEnable, (c >= 17 && c <= 22) ? 0 : 1);
      chk("t4_err", timeout_err, c >= 17 ? 1 : 0);
      chk("t4_ack", ack, c == 23 ? 4'b0100 : 4'b0000);
      clr_err = (c == 16);
      if (c == 23) req = '0;
    end
    chk("t4_dev", clkDevide, 7);
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    chk("t4_err_cleared", timeout_err, 0);
    @(negedge clk);
    req_code = 16'h0007;
    req = 4'b0001;
    sb.push_back('{0, 4'd7});
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      chk("t5_en", clkEnable, 1);
      chk("t5_ack", ack, c == 2 ? 4'b0001 : 4'b0000);
      if (c == 2) req = '0;
    end
    @(negedge clk);
    halt = 1'b1;
    @(posedge clk); #1;
    chk("halt_idle_en", clkEnable, 0);
    halt = 1'b0;
    @(posedge clk); #1;
    chk("halt_release_en", clkEnable, 1);
    do_reset();
    div_clk = 1'b0;
    @(negedge clk);
    req_code = 16'h0050;
    req = 4'b0010;
    sb.push_back('{1, 4'd5});
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      chk("t6_en", clkEnable, c >= 2 ? 0 : 1);
      if (c == 4) halt = 1'b1;
    end
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("t6_rst_dev", clkDevide, 0);
    chk("t6_rst_en", clkEnable, 1);
    chk("t6_rst_ack", ack, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_owner", owner, 0);
    req = '0;
    halt = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("t6_post_en", clkEnable, 1);
      chk("t6_post_ack", ack, 0);
      chk("t6_post_busy", busy, 0);
    end
    chk("sb_empty_end", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sm_clk_div_ctrl.md
Name: sm_clk_div_ctrl

Overview:
Controller and arbiter for the shared clock divider (`sm_clk_divider`). It drives the divider's `clkDevide` select and `clkEnable` count-enable. It accepts divide-code change requests from N_REQ requesters and grants them round-robin. Each change is sequenced safely: wait for divided clock low, freeze the counter, apply the code, settle, resume, acknowledge. It also provides a global halt and a sticky timeout flag.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- RESET_CODE, 4'd0, `clkDevide` value after reset.
- SETTLE_CYCLES, 4, cycles the counter stays frozen after a code change (≥1).
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for divided clock low before forcing the switch.

Ports:
- clk, in, 1, system clock; same clock as the divider.
- rst_n, in, 1, reset; asynchronous, active-low.
- req, in, N_REQ, per-requester change request (level).
- req_code, in, 4*N_REQ, requester i's code in bits [4i+3:4i].
- ack, out, N_REQ, one-cycle completion pulse to the granted requester.
- div_clk, in, 1, divider `clkOut`, fed back.
- halt, in, 1, level; forces `clkEnable` low while high.
- clr_err, in, 1, clears `timeout_err`.
- clkDevide, out, 4, divide select to the divider.
- clkEnable, out, 1, counter enable to the divider.
- busy, out, 1, high whenever FSM is not IDLE.
- owner, out, $clog2(N_REQ), index of the current or last granted requester.
- timeout_err, out, 1, sticky; a switch was forced on timeout.

Behaviour:
- Reset values (async, rst_n low):
  - clkDevide=RESET_CODE, clkEnable=1, ack=0, busy=0, owner=0, timeout_err=0.
  - Round-robin pointer=0, state=IDLE, all counters 0.
- All outputs are registered. div_clk is registered once internally as div_q before use.
- FSM states: IDLE, WAIT_LOW, PAUSE, APPLY, SETTLE, ACK.
- IDLE:
  - If any req bit is high, grant the first requester at or after the RR pointer (wrap-around).
  - Latch its code and index into owner.
  - If the latched code equals clkDevide, go to ACK (no-op, counter never frozen); otherwise go to WAIT_LOW.
- WAIT_LOW:
  - Leave when div_q==0 → PAUSE.
  - Otherwise, when the wait counter reaches TIMEOUT_CYCLES-1 → PAUSE and set timeout_err.
- PAUSE: clkEnable=0 for 1 cycle → APPLY.
- APPLY: clkDevide ← latched code; clkEnable=0; → SETTLE with the settle counter cleared.
- SETTLE: clkEnable=0 for SETTLE_CYCLES cycles → ACK.
- ACK:
  - ack[owner]=1 for exactly one cycle; clkEnable restored.
  - RR pointer ← owner+1 (mod N_REQ); → IDLE.
- Next-state rule for clkEnable: clkEnable_next = !halt && next_state ∉ {PAUSE, APPLY, SETTLE}.
- Latency: cycle 0 is the IDLE cycle that samples req. With div_q already low, ack is high in cycle 4+SETTLE_CYCLES (cycle 8 at defaults). A no-op request acks in cycle 2.
- Requester rules:
  - Hold req and req_code stable until ack.
  - Deassert req in the ack cycle or later.
  - A req withdrawn before grant is ignored.
  - A req withdrawn after grant still completes, and ack still pulses.
  - A requester whose req stays high after ack is re-eligible only after the other pending requesters are served (RR fairness).
- Simultaneous requests: exactly one grant per transaction. Never more than one ack bit high.
- halt:
  - Overrides clkEnable to 0 in every state, including mid-transaction.
  - Does not stall the FSM; transactions complete under halt.
  - Deasserting halt restores clkEnable on the next cycle unless the FSM is in PAUSE, APPLY or SETTLE.
- timeout_err: set has priority over clr_err in the same cycle.
- Reset asserted mid-transaction aborts immediately to reset values; no ack is issued.

Decomposition:
- Package sm_clk_ctrl_pkg holds:
  - the state enum typedef;
  - CODE_W=4;
  - default SETTLE/TIMEOUT constants.
- Sub-module sm_rr_arbiter (parameter N):
  - inputs: req, pointer;
  - outputs: one-hot grant, grant index, valid;
  - purely combinational.
- The FSM, counters and output registers stay in sm_clk_div_ctrl.

Test Plan:
1. Reset release with no req: clkDevide=0, clkEnable=1, busy=0, ack=0 hold for 20 cycles.
2. req[1]=1, code=5, div_clk=0: clkEnable low in cycles 2..7, clkDevide=5 from cycle 4, ack[1] high in cycle 8 only, owner=1.
3. req=4'b1011 simultaneous, codes 3,6,–,9, held until each ack: grants occur in order 0,1,3. Each ack is a single pulse and the acks never overlap.
4. div_clk held high, TIMEOUT_CYCLES=16, req[2] code=7: PAUSE entered after 16 wait cycles, timeout_err=1, and the err stays set through clr_err pulsed in the same cycle as the set. A later clr_err clears it.
5. req[0] with code equal to current clkDevide: ack in cycle 2, clkEnable never drops.
6. halt=1 during SETTLE, then rst_n pulsed low mid-SETTLE: clkEnable=0 throughout; after reset clkDevide=RESET_CODE, clkEnable=1, no ack emitted.
